// File: rtl/mbist_data_cmp_if.sv
// Bus between the MBIST controller / SRAM side and the read-data comparator.
// master: drives bist_en, rd_en, rd_addr, exp_data, rd_data; slave: drives results.
interface mbist_data_cmp_if #(
    parameter int ADDR_WD = 9,
    parameter int DATA_WD = 32
);
    logic               bist_en;
    logic               rd_en;
    logic [ADDR_WD-1:0] rd_addr;
    logic [DATA_WD-1:0] exp_data;
    logic [DATA_WD-1:0] rd_data;
    logic               Error;
    logic [ADDR_WD-1:0] ErrorAddr;
    logic [3:0]         err_cnt;
    logic [DATA_WD-1:0] err_syn;
    logic               bist_fail;
    logic               busy;

    modport master (
        output bist_en, rd_en, rd_addr, exp_data, rd_data,
        input  Error, ErrorAddr, err_cnt, err_syn, bist_fail, busy
    );

    modport slave (
        input  bist_en, rd_en, rd_addr, exp_data, rd_data,
        output Error, ErrorAddr, err_cnt, err_syn, bist_fail, busy
    );
endinterface

// File: rtl/mbist_data_cmp.sv
// MBIST read-data comparator: aligns expected data with SRAM read latency,
// captures each unique failing address once for repair, flags overflow.
// Ports: clk, rst_n (async active-low), bus (slave of mbist_data_cmp_if):
//   in  bist_en, rd_en, rd_addr, exp_data, rd_data
//   out Error, ErrorAddr, err_cnt, err_syn, bist_fail, busy
module mbist_data_cmp #(
    parameter int BIST_ADDR_WD   = 9,
    parameter int BIST_DATA_WD   = 32,
    parameter int BIST_RD_LAT    = 1,
    parameter int BIST_ERR_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    mbist_data_cmp_if.slave bus
);
    localparam int AW  = BIST_ADDR_WD;
    localparam int DW  = BIST_DATA_WD;
    localparam int LAT = BIST_RD_LAT;
    localparam int LIM = BIST_ERR_LIMIT;
    localparam logic [3:0] LIM_CNT = 4'(LIM);

    typedef struct packed {
        logic          vld;
        logic [AW-1:0] addr;
        logic [DW-1:0] exp;
    } stage_t;

    stage_t        pipe_q [LAT];
    stage_t        pipe_d [LAT];
    logic [AW-1:0] list_q [LIM];
    logic [AW-1:0] list_d [LIM];
    logic [3:0]    cnt_q;
    logic [3:0]    cnt_d;
    logic          error_q;
    logic          error_d;
    logic [AW-1:0] err_addr_q;
    logic [AW-1:0] err_addr_d;
    logic [DW-1:0] syn_q;
    logic [DW-1:0] syn_d;
    logic          fail_q;
    logic          fail_d;

    stage_t        last;
    logic          mismatch;
    logic          dup;
    logic          new_err;
    logic          busy;

    // Only the first cnt_q list entries are live; stale slots never match.
    always_comb begin
        last     = pipe_q[LAT-1];
        mismatch = last.vld && (bus.rd_data != last.exp);
        dup      = 1'b0;
        for (int i = 0; i < LIM; i++) begin
            if ((4'(i) < cnt_q) && (list_q[i] == last.addr)) begin
                dup = 1'b1;
            end
        end
        new_err = mismatch && !dup;
    end

    always_comb begin
        for (int i = 0; i < LAT; i++) begin
            pipe_d[i] = '0;
        end
        pipe_d[0].vld  = bus.rd_en & bus.bist_en;
        pipe_d[0].addr = bus.rd_addr;
        pipe_d[0].exp  = bus.exp_data;
        for (int i = 1; i < LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        list_d     = list_q;
        cnt_d      = cnt_q;
        error_d    = 1'b0;
        err_addr_d = err_addr_q;
        syn_d      = syn_q;
        fail_d     = fail_q;

        if (mismatch) begin
            syn_d = last.exp ^ bus.rd_data;
        end

        // The list write lands on the same edge as Error, so a repeat of
        // this address in the very next compare is already a duplicate.
        if (new_err) begin
            if (cnt_q < LIM_CNT) begin
                error_d    = 1'b1;
                err_addr_d = last.addr;
                for (int i = 0; i < LIM; i++) begin
                    if (4'(i) == cnt_q) begin
                        list_d[i] = last.addr;
                    end
                end
                cnt_d = cnt_q + 4'd1;
            end else begin
                fail_d = 1'b1;
            end
        end

        if (!bus.bist_en) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_d[i] = '0;
            end
            for (int i = 0; i < LIM; i++) begin
                list_d[i] = '0;
            end
            cnt_d      = '0;
            error_d    = 1'b0;
            err_addr_d = '0;
            syn_d      = '0;
            fail_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= '0;
            end
            for (int i = 0; i < LIM; i++) begin
                list_q[i] <= '0;
            end
            cnt_q      <= '0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
            syn_q      <= '0;
            fail_q     <= 1'b0;
        end else begin
            pipe_q     <= pipe_d;
            list_q     <= list_d;
            cnt_q      <= cnt_d;
            error_q    <= error_d;
            err_addr_q <= err_addr_d;
            syn_q      <= syn_d;
            fail_q     <= fail_d;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            busy = busy | pipe_q[i].vld;
        end
    end

    assign bus.Error     = error_q;
    assign bus.ErrorAddr = err_addr_q;
    assign bus.err_cnt   = cnt_q;
    assign bus.err_syn   = syn_q;
    assign bus.bist_fail = fail_q;
    assign bus.busy      = busy;
endmodule

// File: tb/tb_mbist_data_cmp.sv
// Bench for mbist_data_cmp: one instance at read latency 1, one at 3,
// both fed the same read stream and checked against a transaction model.
module tb_mbist_data_cmp;
    localparam int AW  = 9;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          bist_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] exp_data = '0;
    logic [DW-1:0] rd_data_a = '0;
    logic [DW-1:0] rd_data_b = '0;

    mbist_data_cmp_if #(.ADDR_WD(AW), .DATA_WD(DW)) bus_a ();
    mbist_data_cmp_if #(.ADDR_WD(AW), .DATA_WD(DW)) bus_b ();

    assign bus_a.bist_en  = bist_en;
    assign bus_a.rd_en    = rd_en;
    assign bus_a.rd_addr  = rd_addr;
    assign bus_a.exp_data = exp_data;
    assign bus_a.rd_data  = rd_data_a;
    assign bus_b.bist_en  = bist_en;
    assign bus_b.rd_en    = rd_en;
    assign bus_b.rd_addr  = rd_addr;
    assign bus_b.exp_data = exp_data;
    assign bus_b.rd_data  = rd_data_b;

    mbist_data_cmp #(
        .BIST_ADDR_WD(AW), .BIST_DATA_WD(DW),
        .BIST_RD_LAT(1), .BIST_ERR_LIMIT(LIM)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

    mbist_data_cmp #(
        .BIST_ADDR_WD(AW), .BIST_DATA_WD(DW),
        .BIST_RD_LAT(3), .BIST_ERR_LIMIT(LIM)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    logic          o_err  [2];
    logic [AW-1:0] o_addr [2];
    logic [3:0]    o_cnt  [2];
    logic [DW-1:0] o_syn  [2];
    logic          o_fail [2];
    logic          o_busy [2];
    assign o_err[0]  = bus_a.Error;
    assign o_err[1]  = bus_b.Error;
    assign o_addr[0] = bus_a.ErrorAddr;
    assign o_addr[1] = bus_b.ErrorAddr;
    assign o_cnt[0]  = bus_a.err_cnt;
    assign o_cnt[1]  = bus_b.err_cnt;
    assign o_syn[0]  = bus_a.err_syn;
    assign o_syn[1]  = bus_b.err_syn;
    assign o_fail[0] = bus_a.bist_fail;
    assign o_fail[1] = bus_b.bist_fail;
    assign o_busy[0] = bus_a.busy;
    assign o_busy[1] = bus_b.busy;

    // Reference model: in-flight reads with their compare cycle, a fault
    // map giving the SRAM corruption mask per address, and the set of
    // known-bad addresses per instance.
    typedef struct {
        int            inst;
        logic [AW-1:0] a;
        logic [DW-1:0] e;
        int            due;
    } rd_t;

    rd_t           fl [$];
    logic [DW-1:0] fault [512];
    logic          m_err  [2];
    logic [AW-1:0] m_addr [2];
    int            m_cnt  [2];
    logic [DW-1:0] m_syn  [2];
    logic          m_fail [2];
    logic [AW-1:0] m_list [2][LIM];

    int now = 0;
    int n_checks = 0;
    int n_errors = 0;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic m_busy(input int k);
        foreach (fl[i]) if (fl[i].inst == k) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear_inst(input int k);
        m_err[k]  = 1'b0;
        m_addr[k] = '0;
        m_cnt[k]  = 0;
        m_syn[k]  = '0;
        m_fail[k] = 1'b0;
    endtask

    task automatic model_clear();
        model_clear_inst(0);
        model_clear_inst(1);
        fl.delete();
    endtask

    task automatic model_edge();
        rd_t keep [$];
        for (int k = 0; k < 2; k++) begin
            m_err[k] = 1'b0;
            if (!bist_en) begin
                model_clear_inst(k);
            end else begin
                foreach (fl[i]) begin
                    if (fl[i].inst == k && fl[i].due == now &&
                        fault[fl[i].a] != '0) begin
                        bit seen;
                        seen = 1'b0;
                        m_syn[k] = fault[fl[i].a];
                        for (int j = 0; j < m_cnt[k]; j++)
                            if (m_list[k][j] == fl[i].a) seen = 1'b1;
                        if (!seen) begin
                            if (m_cnt[k] < LIM) begin
                                m_err[k]  = 1'b1;
                                m_addr[k] = fl[i].a;
                                m_list[k][m_cnt[k]] = fl[i].a;
                                m_cnt[k]++;
                            end else begin
                                m_fail[k] = 1'b1;
                            end
                        end
                    end
                end
            end
        end
        if (bist_en) begin
            foreach (fl[i]) if (fl[i].due != now) keep.push_back(fl[i]);
            fl = keep;
            if (rd_en) begin
                for (int k = 0; k < 2; k++)
                    fl.push_back('{k, rd_addr, exp_data, now + lat_of(k)});
            end
        end else begin
            fl.delete();
        end
    endtask

    // One clock: drive inputs, present SRAM data for reads due now,
    // advance the model at the edge, return 1 time unit after the edge.
    task automatic cycle(input logic en, input logic rv,
                         input logic [AW-1:0] a, input logic [DW-1:0] e);
        bist_en   = en;
        rd_en     = rv;
        rd_addr   = a;
        exp_data  = e;
        rd_data_a = $urandom;
        rd_data_b = $urandom;
        foreach (fl[i]) begin
            if (fl[i].due == now) begin
                if (fl[i].inst == 0) rd_data_a = fl[i].e ^ fault[fl[i].a];
                else rd_data_b = fl[i].e ^ fault[fl[i].a];
            end
        end
        @(posedge clk);
        model_edge();
        now++;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        foreach (fault[i]) fault[i] = '0;
        model_clear();
        #12;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({o_err[k], o_addr[k], o_cnt[k], o_syn[k],
                 o_fail[k], o_busy[k]} !== '0) begin
                n_errors++;
                $display("FAIL reset inst%0d: err=%b addr=%h cnt=%0d syn=%h fail=%b busy=%b, want all 0",
                         k, o_err[k], o_addr[k], o_cnt[k], o_syn[k], o_fail[k], o_busy[k]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_clean_march();
        int pulses [2];
        pulses = '{0, 0};
        for (int a = 0; a < 512; a++) begin
            cycle(1'b1, 1'b1, AW'(a), $urandom);
            for (int k = 0; k < 2; k++) if (o_err[k]) pulses[k]++;
        end
        n_checks++;
        if (o_busy[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL march_busy_a_hold: busy=%b want 1", o_busy[0]);
        end
        cycle(1'b1, 1'b0, '0, '0);
        n_checks++;
        if (o_busy[0] !== 1'b0 || o_busy[1] !== 1'b1) begin
            n_errors++;
            $display("FAIL march_busy_drain: busy a=%b b=%b want 0 1",
                     o_busy[0], o_busy[1]);
        end
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, 1'b0, '0, '0);
            for (int k = 0; k < 2; k++) if (o_err[k]) pulses[k]++;
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pulses[k] != 0 || o_cnt[k] !== 4'd0 ||
                o_fail[k] !== 1'b0 || o_busy[k] !== 1'b0) begin
                n_errors++;
                $display("FAIL clean_march inst%0d: pulses=%0d cnt=%0d fail=%b busy=%b want 0 0 0 0",
                         k, pulses[k], o_cnt[k], o_fail[k], o_busy[k]);
            end
        end
    endtask

    task automatic test_single_fault();
        int first [2];
        int pulses [2];
        int c23;
        first = '{-1, -1};
        pulses = '{0, 0};
        c23 = 0;
        cycle(1'b0, 1'b0, '0, '0);
        fault[9'h023] = 32'h0000_0100;
        for (int a = 9'h021; a <= 9'h025; a++) begin
            if (a == 9'h023) c23 = now;
            cycle(1'b1, 1'b1, AW'(a), $urandom);
            for (int k = 0; k < 2; k++) if (o_err[k]) begin
                pulses[k]++;
                if (first[k] < 0) first[k] = now;
            end
        end
        for (int c = 0; c < 6; c++) begin
            cycle(1'b1, 1'b0, '0, '0);
            for (int k = 0; k < 2; k++) if (o_err[k]) begin
                pulses[k]++;
                if (first[k] < 0) first[k] = now;
            end
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pulses[k] != 1 || first[k] - c23 != lat_of(k) + 1) begin
                n_errors++;
                $display("FAIL single_timing inst%0d: pulses=%0d delay=%0d want 1 %0d",
                         k, pulses[k], first[k] - c23, lat_of(k) + 1);
            end
            n_checks++;
            if (o_addr[k] !== 9'h023 || o_cnt[k] !== 4'd1 ||
                o_syn[k] !== 32'h100 || o_fail[k] !== 1'b0) begin
                n_errors++;
                $display("FAIL single_state inst%0d: addr=%h cnt=%0d syn=%h fail=%b want 023 1 100 0",
                         k, o_addr[k], o_cnt[k], o_syn[k], o_fail[k]);
            end
        end
    endtask

    task automatic test_duplicate();
        int pulses [2];
        logic [AW-1:0] seq [$];
        pulses = '{0, 0};
        cycle(1'b0, 1'b0, '0, '0);
        fault[9'h023] = 32'h0000_0100;
        seq = '{9'h020, 9'h021, 9'h022, 9'h023, 9'h023, 9'h024, 9'h025};
        foreach (seq[i]) begin
            cycle(1'b1, 1'b1, seq[i], $urandom);
            for (int k = 0; k < 2; k++) if (o_err[k]) pulses[k]++;
        end
        for (int c = 0; c < 5; c++) begin
            cycle(1'b1, 1'b0, '0, '0);
            for (int k = 0; k < 2; k++) if (o_err[k]) pulses[k]++;
        end
        fault[9'h023] = 32'h8000_0001;
        for (int i = seq.size() - 1; i >= 0; i--) begin
            cycle(1'b1, 1'b1, seq[i], $urandom);
            for (int k = 0; k < 2; k++) if (o_err[k]) pulses[k]++;
        end
        for (int c = 0; c < 5; c++) begin
            cycle(1'b1, 1'b0, '0, '0);
            for (int k = 0; k < 2; k++) if (o_err[k]) pulses[k]++;
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pulses[k] != 1 || o_cnt[k] !== 4'd1 ||
                o_syn[k] !== 32'h8000_0001) begin
                n_errors++;
                $display("FAIL duplicate inst%0d: pulses=%0d cnt=%0d syn=%h want 1 1 80000001",
                         k, pulses[k], o_cnt[k], o_syn[k]);
            end
        end
        fault[9'h023] = '0;
    endtask

    task automatic test_overflow();
        int pulses [2];
        int run [2];
        int maxrun [2];
        logic [AW-1:0] bad [5];
        pulses = '{0, 0};
        run = '{0, 0};
        maxrun = '{0, 0};
        bad = '{9'h010, 9'h020, 9'h030, 9'h040, 9'h050};
        cycle(1'b0, 1'b0, '0, '0);
        foreach (bad[i]) fault[bad[i]] = $urandom | 32'h1;
        for (int c = 0; c < 11; c++) begin
            if (c < 5) cycle(1'b1, 1'b1, bad[c], $urandom);
            else cycle(1'b1, 1'b0, '0, '0);
            for (int k = 0; k < 2; k++) begin
                if (o_err[k]) begin
                    pulses[k]++;
                    run[k]++;
                    if (run[k] > maxrun[k]) maxrun[k] = run[k];
                end else begin
                    run[k] = 0;
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pulses[k] != 4 || maxrun[k] != 4) begin
                n_errors++;
                $display("FAIL overflow_pulses inst%0d: pulses=%0d run=%0d want 4 4",
                         k, pulses[k], maxrun[k]);
            end
            n_checks++;
            if (o_cnt[k] !== 4'd4 || o_fail[k] !== 1'b1 ||
                o_addr[k] !== 9'h040 || o_syn[k] !== fault[9'h050]) begin
                n_errors++;
                $display("FAIL overflow_state inst%0d: cnt=%0d fail=%b addr=%h syn=%h want 4 1 040 %h",
                         k, o_cnt[k], o_fail[k], o_addr[k], o_syn[k], fault[9'h050]);
            end
        end
        foreach (bad[i]) fault[bad[i]] = '0;
    endtask

    task automatic test_rdlat3();
        int first;
        int c0;
        first = -1;
        c0 = 0;
        cycle(1'b0, 1'b0, '0, '0);
        fault[9'h1F0] = $urandom | 32'h8;
        for (int c = 0; c < 10; c++) begin
            if (c < 5) begin
                if (c == 2) c0 = now;
                cycle(1'b1, 1'b1, AW'(9'h1EE + c), $urandom);
            end else begin
                cycle(1'b1, 1'b0, '0, '0);
            end
            if (o_err[1] && first < 0) first = now;
        end
        n_checks++;
        if (first - c0 != 4 || o_addr[1] !== 9'h1F0 || o_cnt[1] !== 4'd1) begin
            n_errors++;
            $display("FAIL rdlat3: delay=%0d addr=%h cnt=%0d want 4 1f0 1",
                     first - c0, o_addr[1], o_cnt[1]);
        end
        fault[9'h1F0] = '0;
    endtask

    task automatic abort_setup();
        cycle(1'b0, 1'b0, '0, '0);
        fault[9'h100] = 32'h1;
        fault[9'h101] = 32'h2;
        fault[9'h102] = 32'h4;
        fault[9'h103] = 32'h8;
        cycle(1'b1, 1'b1, 9'h100, $urandom);
        cycle(1'b1, 1'b1, 9'h101, $urandom);
        for (int c = 0; c < 5; c++) cycle(1'b1, 1'b0, '0, '0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_cnt[k] !== 4'd2) begin
                n_errors++;
                $display("FAIL abort_pre inst%0d: cnt=%0d want 2", k, o_cnt[k]);
            end
        end
        cycle(1'b1, 1'b1, 9'h102, $urandom);
    endtask

    task automatic abort_after(input string tag);
        int pulses [2];
        pulses = '{0, 0};
        for (int c = 0; c < 6; c++) begin
            cycle(1'b1, 1'b0, '0, '0);
            for (int k = 0; k < 2; k++) if (o_err[k]) pulses[k]++;
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pulses[k] != 0 || o_cnt[k] !== 4'd0) begin
                n_errors++;
                $display("FAIL %s_late inst%0d: pulses=%0d cnt=%0d want 0 0",
                         tag, k, pulses[k], o_cnt[k]);
            end
        end
    endtask

    task automatic test_abort_reset();
        abort_setup();
        bist_en  = 1'b1;
        rd_en    = 1'b1;
        rd_addr  = 9'h103;
        exp_data = $urandom;
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({o_err[k], o_addr[k], o_cnt[k], o_syn[k],
                 o_fail[k], o_busy[k]} !== '0) begin
                n_errors++;
                $display("FAIL abort_rst inst%0d: err=%b cnt=%0d busy=%b want all 0",
                         k, o_err[k], o_cnt[k], o_busy[k]);
            end
        end
        @(posedge clk);
        now++;
        #2;
        rst_n = 1'b1;
        abort_after("abort_rst");
    endtask

    task automatic test_abort_en();
        abort_setup();
        cycle(1'b0, 1'b1, 9'h103, $urandom);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({o_err[k], o_addr[k], o_cnt[k], o_syn[k],
                 o_fail[k], o_busy[k]} !== '0) begin
                n_errors++;
                $display("FAIL abort_en inst%0d: err=%b cnt=%0d busy=%b want all 0",
                         k, o_err[k], o_cnt[k], o_busy[k]);
            end
        end
        abort_after("abort_en");
        for (int a = 9'h100; a <= 9'h103; a++) fault[a] = '0;
    endtask

    task automatic test_random();
        int bad_cycles [2];
        bad_cycles = '{0, 0};
        cycle(1'b0, 1'b0, '0, '0);
        foreach (fault[i]) fault[i] = '0;
        for (int i = 0; i < 6; i++) fault[$urandom_range(15, 0)] = $urandom | 32'h10;
        for (int c = 0; c < 500; c++) begin
            cycle(($urandom_range(99, 0) >= 2), ($urandom_range(9, 0) < 7),
                  AW'($urandom_range(15, 0)), $urandom);
            for (int k = 0; k < 2; k++) begin
                if (o_err[k] !== m_err[k] || o_addr[k] !== m_addr[k] ||
                    o_cnt[k] !== 4'(m_cnt[k]) || o_syn[k] !== m_syn[k] ||
                    o_fail[k] !== m_fail[k] || o_busy[k] !== m_busy(k)) begin
                    if (bad_cycles[k] < 5)
                        $display("FAIL random inst%0d cyc%0d: err=%b addr=%h cnt=%0d syn=%h fail=%b busy=%b want %b %h %0d %h %b %b",
                                 k, now, o_err[k], o_addr[k], o_cnt[k], o_syn[k], o_fail[k], o_busy[k],
                                 m_err[k], m_addr[k], m_cnt[k], m_syn[k], m_fail[k], m_busy(k));
                    bad_cycles[k]++;
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (bad_cycles[k] != 0) begin
                n_errors++;
                $display("FAIL random_total inst%0d: bad_cycles=%0d want 0",
                         k, bad_cycles[k]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_clean_march();
        test_single_fault();
        test_duplicate();
        test_overflow();
        test_rdlat3();
        test_abort_reset();
        test_abort_en();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
